ex_stage_p: RTL and testbench
=============================

EX_STAGE_P -- requirements
Module: ex_stage_p

Interface
REQ-001 Parameter DATA_W, default 32, datapath width in bits (legal: 16, 32, 64).
REQ-002 Parameter DEST_W, default 5, destination register index width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID slot holds a real instruction.
REQ-006 id_inA, id_inB, id_imm  in  DATA_W each  register operands A/B; sign-extended immediate.
REQ-007 id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift  in  1 each  control bits, ID meaning.
REQ-008 id_aluc  in  4  ALU opcode; id_destR  in  DEST_W  destination register.
REQ-009 id_fwdA, id_fwdB  in  2 each  forward select: 00 register, 01 MEM, 10 WB, 11 register.
REQ-010 mem_fwd_data, wb_fwd_data  in  DATA_W each  forwarded results.
REQ-011 mem_stall  in  1  downstream hold; ex_flush  in  1  kill the instruction in EX.
REQ-012 ex_stall  out  1  EX busy; hazard unit must freeze IF/ID.
REQ-013 ex_valid, ex_wreg, ex_m2reg, ex_wmem  out  1 each  qualified outputs to MEM.
REQ-014 ex_aluR, ex_inB  out  DATA_W each  result; forwarded B for stores.
REQ-015 ex_destR  out  DEST_W; ex_zero  out  1  ex_aluR == 0.

Function
REQ-016 ID/EX register shall capture all id_* inputs on a rising edge when ex_stall=0 and mem_stall=0.
REQ-017 When ex_flush=1, the register shall clear valid/wreg/wmem/m2reg on that edge, overriding capture and stall, and shall abort any multiply.
REQ-018 Operand A = shift ? zero-extended imm[10:6] : fwdA-selected data; B = aluimm ? imm : fwdB-selected data; ex_inB = fwdB-selected data.
REQ-019 ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 0/1), 7 SLL, 8 SRL, 9 SRA (amount = A[log2(DATA_W)-1:0]), A LUI (B<<16), B MUL, C-F result 0.
REQ-020 ADD/SUB shall wrap modulo 2^DATA_W; no overflow trap.
REQ-021 Non-MUL ops: result combinational from ID/EX register; latency 1 cycle after capture.
REQ-022 MUL FSM states IDLE, BUSY, DONE; IDLE->BUSY when a valid MUL sits in EX, latching both operands and clearing the counter.
REQ-023 BUSY: one shift-add step per cycle; after DATA_W steps -> DONE; ex_aluR = low DATA_W bits of product.
REQ-024 DONE->IDLE on the edge the ID/EX register next captures or flushes.
REQ-025 ex_stall=1 in IDLE-with-valid-MUL and in BUSY; 0 otherwise; MUL latency DATA_W+1 cycles from capture.
REQ-026 ex_valid/ex_wreg/ex_wmem/ex_m2reg shall be 0 while ex_stall=1 (bubble to MEM).
REQ-027 mem_stall during BUSY shall not pause the counter; DONE holds result until released.
REQ-028 Back-to-back MULs: second starts the cycle after first leaves DONE.

Reset
REQ-029 rst shall clear the ID/EX register (valid=0, all controls 0, data 0), FSM to IDLE, counter 0; all outputs 0, including mid-multiply.

Configuration
REQ-030 Macro EX_STAGE_MUL_EN: defined -> MUL FSM and sub-module present; undefined -> opcode B yields 0 in one cycle, ex_stall tied 0, no FSM state.

Structure
REQ-031 Package ex_pkg shall hold the 4-bit ALU opcode constants, forward-select constants and FSM state type.
REQ-032 Sub-module ex_mul_seq shall hold the iterative multiplier (start, operands, busy, done, product).

Verification
REQ-033 ADD A=0x7FFFFFFF, B=1 -> ex_aluR=0x80000000, ex_zero=0 one cycle after capture.
REQ-034 SUB with fwdA=01, mem_fwd_data=5, B=5 -> ex_aluR=0, ex_zero=1.
REQ-035 MUL 6x7 (EX_STAGE_MUL_EN, DATA_W=32) -> ex_stall high 33 cycles, ex_valid=0 meanwhile, then ex_aluR=42, ex_valid=1.
REQ-036 ex_flush during BUSY -> next cycle ex_stall=0, ex_valid=0, FSM IDLE.
REQ-037 rst asserted mid-MUL -> next cycle all outputs 0; subsequent ADD 2+3 -> 5.
REQ-038 SRA A-field 4, B=0xF0000000 -> ex_aluR=0xFF000000; mem_stall held 3 cycles keeps it stable.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: ALU opcodes, forward selects
// and the multiplier FSM state type.
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;
  localparam logic [3:0] ALU_LUI = 4'hA;
  localparam logic [3:0] ALU_MUL = 4'hB;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W steps,
// result held in DONE until the owner acknowledges it. State exposed on 'state'.
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output mul_state_t        state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (abort) begin
      state <= MUL_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state  <= MUL_BUSY;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
          end
        end
        MUL_BUSY: begin
          // Only the low DATA_W product bits are kept, so mcand may overflow freely.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (ack) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage_p.sv
// Pipeline execute stage: ID/EX register, operand forwarding, ALU and an optional
// iterative multiplier enabled by defining EX_STAGE_MUL_EN.
module ex_stage_p
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_inA,
  input  logic [DATA_W-1:0] id_inB,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic              id_aluimm,
  input  logic              id_shift,
  input  logic [3:0]        id_aluc,
  input  logic [DEST_W-1:0] id_destR,
  input  logic [1:0]        id_fwdA,
  input  logic [1:0]        id_fwdB,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic              ex_valid,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_wmem,
  output logic [DATA_W-1:0] ex_aluR,
  output logic [DATA_W-1:0] ex_inB,
  output logic [DEST_W-1:0] ex_destR,
  output logic              ex_zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic              valid_r, wreg_r, m2reg_r, wmem_r, aluimm_r, shift_r;
  logic [3:0]        aluc_r;
  logic [1:0]        fwda_r, fwdb_r;
  logic [DATA_W-1:0] ina_r, inb_r, imm_r;
  logic [DEST_W-1:0] destr_r;

  logic              capture;
  logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b, alu_r, mul_result;
  logic [SH_W-1:0]   shamt;

  // Handshake: ID offers an instruction every cycle; it is taken on an edge where
  // capture is high (EX not stalled, MEM not holding); ex_flush beats both.
  assign capture = ~ex_stall & ~mem_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      wreg_r   <= 1'b0;
      m2reg_r  <= 1'b0;
      wmem_r   <= 1'b0;
      aluimm_r <= 1'b0;
      shift_r  <= 1'b0;
      aluc_r   <= '0;
      fwda_r   <= '0;
      fwdb_r   <= '0;
      ina_r    <= '0;
      inb_r    <= '0;
      imm_r    <= '0;
      destr_r  <= '0;
    end else begin
      if (capture) begin
        valid_r  <= id_valid;
        wreg_r   <= id_wreg;
        m2reg_r  <= id_m2reg;
        wmem_r   <= id_wmem;
        aluimm_r <= id_aluimm;
        shift_r  <= id_shift;
        aluc_r   <= id_aluc;
        fwda_r   <= id_fwdA;
        fwdb_r   <= id_fwdB;
        ina_r    <= id_inA;
        inb_r    <= id_inB;
        imm_r    <= id_imm;
        destr_r  <= id_destR;
      end
      if (ex_flush) begin
        valid_r <= 1'b0;
        wreg_r  <= 1'b0;
        m2reg_r <= 1'b0;
        wmem_r  <= 1'b0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] fwd_pick(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] reg_v,
                                                 input logic [DATA_W-1:0] mem_v,
                                                 input logic [DATA_W-1:0] wb_v);
    logic [DATA_W-1:0] f;
    case (sel)
      FWD_MEM:     f = mem_v;
      FWD_WB:      f = wb_v;
      FWD_REG:     f = reg_v;
      FWD_REG_ALT: f = reg_v;
      default:     f = reg_v;
    endcase
    return f;
  endfunction

  assign fwd_a = fwd_pick(fwda_r, ina_r, mem_fwd_data, wb_fwd_data);
  assign fwd_b = fwd_pick(fwdb_r, inb_r, mem_fwd_data, wb_fwd_data);
  assign op_a  = shift_r ? {{(DATA_W - 5){1'b0}}, imm_r[10:6]} : fwd_a;
  assign op_b  = aluimm_r ? imm_r : fwd_b;
  assign shamt = op_a[SH_W-1:0];

  always_comb begin
    alu_r = '0;
    case (aluc_r)
      ALU_ADD: alu_r = op_a + op_b;
      ALU_SUB: alu_r = op_a - op_b;
      ALU_AND: alu_r = op_a & op_b;
      ALU_OR:  alu_r = op_a | op_b;
      ALU_XOR: alu_r = op_a ^ op_b;
      ALU_NOR: alu_r = ~(op_a | op_b);
      ALU_SLT: alu_r = {{(DATA_W - 1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_r = op_b << shamt;
      ALU_SRL: alu_r = op_b >> shamt;
      ALU_SRA: alu_r = $signed(op_b) >>> shamt;
      ALU_LUI: alu_r = op_b << 16;
      ALU_MUL: alu_r = mul_result;
      default: alu_r = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  mul_state_t        mul_state;
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;

  assign mul_start = valid_r & (aluc_r == ALU_MUL);

  ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (ex_flush),
    .ack     (capture),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  assign ex_stall   = ((mul_state == MUL_IDLE) & mul_start) | mul_busy;
  assign mul_result = mul_done ? mul_product : '0;
`else
  assign ex_stall   = 1'b0;
  assign mul_result = '0;
`endif

  // While stalled MEM sees a bubble; ex_zero is qualified so reset drives it low.
  assign ex_valid = valid_r & ~ex_stall;
  assign ex_wreg  = wreg_r  & ~ex_stall;
  assign ex_m2reg = m2reg_r & ~ex_stall;
  assign ex_wmem  = wmem_r  & ~ex_stall;
  assign ex_aluR  = alu_r;
  assign ex_inB   = fwd_b;
  assign ex_destR = destr_r;
  assign ex_zero  = ex_valid & (alu_r == '0);

endmodule

// File: tb/tb_ex_stage_p.sv
// Self-checking bench for ex_stage_p: directed cases plus randomized traffic against
// an instruction-level model. Multiply cases depend on EX_STAGE_MUL_EN.
module tb_ex_stage_p;

  localparam int DW = 32;
  localparam int RW = 5;
`ifdef EX_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift;
  logic [DW-1:0] id_inA, id_inB, id_imm, mem_fwd_data, wb_fwd_data;
  logic [3:0]    id_aluc;
  logic [RW-1:0] id_destR;
  logic [1:0]    id_fwdA, id_fwdB;
  logic          mem_stall, ex_flush;
  logic          ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_zero;
  logic [DW-1:0] ex_aluR, ex_inB;
  logic [RW-1:0] ex_destR;

  int errors = 0;
  int checks = 0;

  ex_stage_p #(.DATA_W(DW), .DEST_W(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inA(id_inA), .id_inB(id_inB),
    .id_imm(id_imm), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluimm(id_aluimm), .id_shift(id_shift), .id_aluc(id_aluc), .id_destR(id_destR),
    .id_fwdA(id_fwdA), .id_fwdB(id_fwdB), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_wmem(ex_wmem), .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_zero(ex_zero)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model: the instruction currently held in EX ----------------
  bit            model_ok = 1'b0;
  logic          m_valid, m_wreg, m_m2reg, m_wmem, m_aluimm, m_shift;
  logic [3:0]    m_aluc;
  logic [1:0]    m_fwdA, m_fwdB;
  logic [DW-1:0] m_inA, m_inB, m_imm, m_prod;
  logic [RW-1:0] m_dest;
  int            m_left;   // stall cycles still owed by a multiply in EX

  function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] r);
    if (s == 2'd1) return mem_fwd_data;
    if (s == 2'd2) return wb_fwd_data;
    return r;
  endfunction

  function automatic logic [DW-1:0] m_opa();
    if (m_shift) return (m_imm >> 6) % 32;
    return pick(m_fwdA, m_inA);
  endfunction

  function automatic logic [DW-1:0] m_opb();
    return m_aluimm ? m_imm : pick(m_fwdB, m_inB);
  endfunction

  function automatic logic [DW-1:0] model_result();
    logic [DW-1:0] a, b;
    int            amt;
    a   = m_opa();
    b   = m_opb();
    amt = int'(a % DW);
    case (int'(m_aluc))
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (int'(a) < int'(b)) ? 1 : 0;
      7:  return b << amt;
      8:  return b >> amt;
      9:  return DW'($signed(b) >>> amt);
      10: return b << 16;
      11: return MUL_EN ? m_prod : '0;
      default: return '0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic          e_stall;
    logic [DW-1:0] e_res;
    if (!model_ok) return;
    e_stall = (m_left > 0);
    chk("stall", ex_stall, e_stall);
    chk("ctl", {ex_valid, ex_wreg, ex_m2reg, ex_wmem},
        {m_valid, m_wreg, m_m2reg, m_wmem} & {4{~e_stall}});
    if (m_valid && !e_stall) begin
      e_res = model_result();
      chk("aluR", ex_aluR, e_res);
      chk("zero", ex_zero, e_res == '0);
      chk("inB", ex_inB, pick(m_fwdB, m_inB));
      chk("destR", ex_destR, m_dest);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_update();
    bit take;
    if (rst) begin
      {m_valid, m_wreg, m_m2reg, m_wmem, m_aluimm, m_shift} = '0;
      m_aluc = '0; m_fwdA = '0; m_fwdB = '0;
      m_inA = '0; m_inB = '0; m_imm = '0; m_dest = '0; m_prod = '0;
      m_left = 0;
      model_ok = 1'b1;
      return;
    end
    take = (m_left == 0) && !mem_stall;
    if (m_left == DW + 1) m_prod = m_opa() * m_opb();
    if (m_left > 0) m_left--;
    if (take) begin
      m_valid = id_valid; m_wreg = id_wreg; m_m2reg = id_m2reg; m_wmem = id_wmem;
      m_aluimm = id_aluimm; m_shift = id_shift; m_aluc = id_aluc;
      m_fwdA = id_fwdA; m_fwdB = id_fwdB;
      m_inA = id_inA; m_inB = id_inB; m_imm = id_imm; m_dest = id_destR;
      m_left = (MUL_EN && id_valid && id_aluc == 4'hB) ? DW + 1 : 0;
    end
    if (ex_flush) begin
      {m_valid, m_wreg, m_m2reg, m_wmem} = '0;
      m_left = 0;
    end
  endtask

  // One cycle: settle, compare, step model, move to the next falling edge.
  task automatic cyc();
    #1;
    check_model();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] imm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic sh, input logic ai, input logic [RW-1:0] dest);
    id_valid = 1'b1; id_aluc = op; id_inA = a; id_inB = b; id_imm = imm;
    id_fwdA = fa; id_fwdB = fb; id_shift = sh; id_aluimm = ai; id_destR = dest;
    id_wreg = 1'b1; id_m2reg = 1'b0; id_wmem = 1'b0;
  endtask

  task automatic bubble();
    id_valid = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0;
    id_aluc = '0; id_inA = '0; id_inB = '0; id_imm = '0;
    id_fwdA = '0; id_fwdB = '0; id_shift = 1'b0; id_aluimm = 1'b0; id_destR = '0;
  endtask

  task automatic rand_inputs();
    logic [3:0] op;
    id_valid  = ($urandom_range(0, 3) != 0);
    op        = 4'($urandom_range(0, 15));
    if (op == 4'hB && $urandom_range(0, 3) != 0) op = 4'h0;
    id_aluc   = op;
    id_inA    = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom;
    id_inB    = ($urandom_range(0, 3) == 0) ? id_inA : $urandom;
    id_imm    = $urandom;
    id_fwdA   = 2'($urandom_range(0, 3));
    id_fwdB   = 2'($urandom_range(0, 3));
    id_shift  = ($urandom_range(0, 4) == 0);
    id_aluimm = ($urandom_range(0, 3) == 0);
    id_wreg   = 1'($urandom_range(0, 1));
    id_m2reg  = 1'($urandom_range(0, 1));
    id_wmem   = 1'($urandom_range(0, 1));
    id_destR  = RW'($urandom_range(0, 31));
    mem_fwd_data = $urandom;
    wb_fwd_data  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
    mem_stall = ($urandom_range(0, 4) == 0);
    ex_flush  = ($urandom_range(0, 19) == 0);
    rst       = ($urandom_range(0, 299) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; mem_stall = 1'b0; ex_flush = 1'b0;
    mem_fwd_data = '0; wb_fwd_data = '0;
    bubble();
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_ctl", {ex_valid, ex_stall, ex_wreg, ex_m2reg, ex_wmem, ex_zero}, '0);
    chk("rst_data", {ex_aluR, ex_inB}, '0);
    chk("rst_dest", ex_destR, '0);

    // ADD wraps to the sign bit
    drive(4'h0, 32'h7FFF_FFFF, 32'h1, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3);
    cyc();
    bubble(); #1;
    chk("add_res", ex_aluR, 32'h8000_0000);
    chk("add_zero", ex_zero, 1'b0);
    chk("add_valid", ex_valid, 1'b1);
    cyc();

    // SUB with A forwarded from MEM
    mem_fwd_data = 32'd5;
    drive(4'h1, 32'd99, 32'd5, '0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd4);
    cyc();
    bubble(); #1;
    chk("sub_res", ex_aluR, 32'h0);
    chk("sub_zero", ex_zero, 1'b1);
    cyc();

    // SRA by shift field 4, held through three cycles of mem_stall
    drive(4'h9, '0, 32'hF000_0000, 32'd4 << 6, 2'b00, 2'b00, 1'b1, 1'b0, 5'd7);
    cyc();
    bubble(); mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sra_hold", ex_aluR, 32'hFF00_0000);
      chk("sra_valid", ex_valid, 1'b1);
      cyc();
    end
    mem_stall = 1'b0;
    cyc();

    // Flush on the capture edge kills the instruction
    drive(4'h0, 32'd1, 32'd1, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd2);
    ex_flush = 1'b1;
    cyc();
    ex_flush = 1'b0; bubble(); #1;
    chk("flush_cap", {ex_valid, ex_wreg}, 2'b00);
    cyc();

`ifdef EX_STAGE_MUL_EN
    // MUL 6x7: stall count and result
    drive(4'hB, 32'd6, 32'd7, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd9);
    cyc();
    bubble();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!ex_stall) break;
      n++;
      cyc();
    end
    chk("mul_stall_cnt", n, 33);
    chk("mul_res", ex_aluR, 32'd42);
    chk("mul_valid", ex_valid, 1'b1);
    cyc();

    // Flush while BUSY
    drive(4'hB, 32'd3, 32'd5, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd9);
    cyc();
    bubble();
    repeat (5) cyc();
    ex_flush = 1'b1;
    cyc();
    ex_flush = 1'b0; #1;
    chk("mflush_stall", ex_stall, 1'b0);
    chk("mflush_valid", ex_valid, 1'b0);
    chk("mflush_state", dut.u_mul.state, ex_pkg::MUL_IDLE);
    cyc();

    // Back-to-back: second MUL waits at the ID slot
    drive(4'hB, 32'd9, 32'd9, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd1);
    cyc();
    drive(4'hB, 32'd10, 32'd11, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd2);
    for (int i = 0; i < 100 && ex_stall; i++) cyc();
    #1;
    chk("b2b_first", ex_aluR, 32'd81);
    cyc();
    bubble();
    for (int i = 0; i < 100 && ex_stall; i++) cyc();
    #1;
    chk("b2b_second", ex_aluR, 32'd110);
    cyc();

    // Reset mid-multiply
    drive(4'hB, 32'd123, 32'd456, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd5);
    cyc();
    bubble();
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("mrst_ctl", {ex_valid, ex_stall, ex_wreg, ex_m2reg, ex_wmem, ex_zero}, '0);
    chk("mrst_data", {ex_aluR, ex_inB, 27'd0, ex_destR}, '0);
`else
    // Without the multiplier, opcode B gives 0 in one cycle and never stalls
    drive(4'hB, 32'd6, 32'd7, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd9);
    cyc();
    bubble(); #1;
    chk("mul_off_stall", ex_stall, 1'b0);
    chk("mul_off_res", ex_aluR, 32'd0);
    chk("mul_off_valid", ex_valid, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`endif

    // ADD 2+3 after reset
    drive(4'h0, 32'd2, 32'd3, '0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd6);
    cyc();
    bubble(); #1;
    chk("post_rst_add", ex_aluR, 32'd5);
    cyc();

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cyc();
    end
    rst = 1'b0; mem_stall = 1'b0; ex_flush = 1'b0;
    bubble();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
